// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues one instruction-memory
// read at a time, and holds each returned word in the instruction register until
// decode accepts it. PC redirects arrive on the shared register-load strobe.
// Optional build macro FETCH_STATS_EN adds a saturating 16-bit count of delivered
// instructions on output fetch_count.
module fetch_unit #(
    parameter int unsigned WORD_SIZE = 19,
    parameter int unsigned ADDR_SIZE = 20,
    parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req_valid,
    output logic [ADDR_SIZE-1:0] imem_req_addr,
    input  logic                 imem_req_ready,
    input  logic                 imem_rsp_valid,
    input  logic [WORD_SIZE-1:0] imem_rsp_data,
    output logic                 ir_valid,
    output logic [WORD_SIZE-1:0] ir_data,
    output logic [ADDR_SIZE-1:0] ir_pc,
    input  logic                 ir_ready,
    input  logic                 load_en,
    input  logic [2:0]           load_sel,
    input  logic [ADDR_SIZE-1:0] load_addr
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]          fetch_count
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [2:0] LOAD_PC = 3'b000;

    logic [1:0]           state, state_next;
    logic [ADDR_SIZE-1:0] pc, pc_next;
    logic                 discard, discard_next;
    logic [WORD_SIZE-1:0] ir_data_next;
    logic [ADDR_SIZE-1:0] ir_pc_next;
    logic                 redir;
    logic                 consumed;

    assign redir = load_en && (load_sel == LOAD_PC);

    // State, PC and response-discard flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            discard <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            discard <= discard_next;
        end
    end

    // Next-state, PC, and instruction-register update logic
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        discard_next = discard;
        ir_data_next = ir_data;
        ir_pc_next   = ir_pc;
        consumed     = 1'b0;
        case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_next = WAIT;
                    if (redir) begin
                        // Old-address request is already in flight; drop its data
                        discard_next = 1'b1;
                        pc_next      = load_addr;
                    end
                end else if (redir) begin
                    pc_next = load_addr;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard || redir) begin
                        discard_next = 1'b0;
                        state_next   = REQ;
                        if (redir) begin
                            pc_next = load_addr;
                        end
                    end else begin
                        ir_data_next = imem_rsp_data;
                        ir_pc_next   = pc;
                        state_next   = HOLD;
                    end
                end else if (redir) begin
                    discard_next = 1'b1;
                    pc_next      = load_addr;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_next    = load_addr;
                    state_next = REQ;
                end else if (ir_ready) begin
                    pc_next    = pc + ADDR_SIZE'(1);
                    state_next = REQ;
                    consumed   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_valid <= 1'b0;
            imem_req_addr  <= RESET_PC;
            ir_valid       <= 1'b0;
            ir_data        <= '0;
            ir_pc          <= '0;
        end else begin
            imem_req_valid <= (state_next == REQ);
            imem_req_addr  <= pc_next;
            ir_valid       <= (state_next == HOLD);
            ir_data        <= ir_data_next;
            ir_pc          <= ir_pc_next;
        end
    end

`ifdef FETCH_STATS_EN
    // Saturating count of instructions handed to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'h0000;
        end else if (consumed && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`else
    logic unused_consumed;
    assign unused_consumed = consumed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors plus hand-written sequences for fetch_unit.
// Memory model answers mem[a] = a + 0x100 after a programmable latency.
module tb_fetch_unit;

    localparam int unsigned WS = 19;
    localparam int unsigned AS = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req_valid;
    logic [AS-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [WS-1:0] imem_rsp_data;
    logic          ir_valid;
    logic [WS-1:0] ir_data;
    logic [AS-1:0] ir_pc;
    logic          ir_ready;
    logic          load_en;
    logic [2:0]    load_sel;
    logic [AS-1:0] load_addr;
`ifdef FETCH_STATS_EN
    logic [15:0]   fetch_count;
    logic [15:0]   cnt_before;
`endif

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ir_valid       (ir_valid),
        .ir_data        (ir_data),
        .ir_pc          (ir_pc),
        .ir_ready       (ir_ready),
        .load_en        (load_en),
        .load_sel       (load_sel),
        .load_addr      (load_addr)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          irr;
        logic          rv;
        logic [AS-1:0] ra;
        logic          iv;
        logic [WS-1:0] id;
        logic [AS-1:0] ip;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    int            lat = 0;
    bit            pend = 1'b0;
    int            cnt = 0;
    logic [AS-1:0] paddr = '0;
    int            req_cnt = 0;
    bit            saw5 = 1'b0;
    int            r0;
    vec_t          vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: memory model sees the handshake, then outputs are sampled #1 after the edge
    task automatic tick();
        bit            acc;
        logic [AS-1:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        if (acc) begin
            chk("single_outstanding", 32'(pend), 32'd0);
            req_cnt++;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (acc) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = a;
        end
        if (pend) begin
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = WS'(paddr + 20'h00100);
                pend           = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (ir_valid && ir_pc == 20'h00005) saw5 = 1'b1;
    endtask

    task automatic run_until_req(input logic [AS-1:0] addr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (imem_req_valid && imem_req_addr == addr) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("reach_req", 32'(found), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 20'h0, 1'b0, 19'h000, 20'h0};
        vecs[1] = '{1'b1, 1'b0, 20'h0, 1'b0, 19'h000, 20'h0};
        vecs[2] = '{1'b1, 1'b0, 20'h0, 1'b1, 19'h100, 20'h0};
        vecs[3] = '{1'b1, 1'b1, 20'h1, 1'b0, 19'h100, 20'h0};
        vecs[4] = '{1'b1, 1'b0, 20'h1, 1'b0, 19'h100, 20'h0};
        vecs[5] = '{1'b1, 1'b0, 20'h1, 1'b1, 19'h101, 20'h1};
        vecs[6] = '{1'b1, 1'b1, 20'h2, 1'b0, 19'h101, 20'h1};
        vecs[7] = '{1'b1, 1'b0, 20'h2, 1'b0, 19'h101, 20'h1};
        vecs[8] = '{1'b1, 1'b0, 20'h2, 1'b1, 19'h102, 20'h2};
        vecs[9] = '{1'b1, 1'b1, 20'h3, 1'b0, 19'h102, 20'h2};

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        ir_ready       = 1'b1;
        load_en        = 1'b0;
        load_sel       = 3'b000;
        load_addr      = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", 32'(imem_req_addr), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir_data", 32'(ir_data), 32'd0);
        chk("rst_ir_pc", 32'(ir_pc), 32'd0);
`ifdef FETCH_STATS_EN
        chk("rst_fetch_count", 32'(fetch_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: zero-wait memory and decode
        for (int i = 0; i < 10; i++) begin
            ir_ready = vecs[i].irr;
            tick();
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].rv));
            chk($sformatf("vec%0d_req_addr", i), 32'(imem_req_addr), 32'(vecs[i].ra));
            chk($sformatf("vec%0d_ir_valid", i), 32'(ir_valid), 32'(vecs[i].iv));
            chk($sformatf("vec%0d_ir_data", i), 32'(ir_data), 32'(vecs[i].id));
            chk($sformatf("vec%0d_ir_pc", i), 32'(ir_pc), 32'(vecs[i].ip));
        end

        // Redirect in WAIT while the response for address 5 is outstanding
        run_until_req(20'h00005);
        lat = 2;
        tick();
        chk("w_after_accept_req_valid", 32'(imem_req_valid), 32'd0);
        load_en   = 1'b1;
        load_sel  = 3'b000;
        load_addr = 20'h00040;
        tick();
        load_en = 1'b0;
        chk("w_redir_req_valid", 32'(imem_req_valid), 32'd0);
        chk("w_redir_ir_valid", 32'(ir_valid), 32'd0);
        tick();
        chk("w_rsp_ir_valid", 32'(ir_valid), 32'd0);
        chk("w_rsp_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("w_new_req_valid", 32'(imem_req_valid), 32'd1);
        chk("w_new_req_addr", 32'(imem_req_addr), 32'h40);
        chk("w_dropped_ir_valid", 32'(ir_valid), 32'd0);
        chk("w_addr5_never_delivered", 32'(saw5), 32'd0);
        lat = 0;
        tick();
        tick();
        chk("w_deliver_ir_valid", 32'(ir_valid), 32'd1);
        chk("w_deliver_ir_data", 32'(ir_data), 32'h140);
        chk("w_deliver_ir_pc", 32'(ir_pc), 32'h40);

        // Redirect wins over a same-cycle ir_ready in HOLD; non-PC select ignored first
`ifdef FETCH_STATS_EN
        cnt_before = fetch_count;
`endif
        ir_ready  = 1'b0;
        load_en   = 1'b1;
        load_sel  = 3'b011;
        load_addr = 20'h00077;
        tick();
        chk("h_other_sel_ir_valid", 32'(ir_valid), 32'd1);
        chk("h_other_sel_req_valid", 32'(imem_req_valid), 32'd0);
        load_sel  = 3'b000;
        load_addr = 20'h00010;
        ir_ready  = 1'b1;
        tick();
        load_en = 1'b0;
        chk("h_redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("h_redir_req_addr", 32'(imem_req_addr), 32'h10);
        chk("h_redir_ir_valid", 32'(ir_valid), 32'd0);
`ifdef FETCH_STATS_EN
        chk("h_redir_not_counted", 32'(fetch_count), 32'(cnt_before));
`endif

        // Backpressure on request then on decode
        imem_req_ready = 1'b0;
        r0 = req_cnt;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("bp_req_valid%0d", i), 32'(imem_req_valid), 32'd1);
            chk($sformatf("bp_req_addr%0d", i), 32'(imem_req_addr), 32'h10);
        end
        imem_req_ready = 1'b1;
        ir_ready       = 1'b0;
        tick();
        tick();
        chk("bp_hold_ir_valid", 32'(ir_valid), 32'd1);
        chk("bp_hold_ir_data", 32'(ir_data), 32'h110);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_ir_valid%0d", i), 32'(ir_valid), 32'd1);
            chk($sformatf("bp_ir_data%0d", i), 32'(ir_data), 32'h110);
            chk($sformatf("bp_ir_pc%0d", i), 32'(ir_pc), 32'h10);
            chk($sformatf("bp_no_req%0d", i), 32'(imem_req_valid), 32'd0);
        end
        chk("bp_one_request", 32'(req_cnt - r0), 32'd1);
        ir_ready = 1'b1;
        tick();
        chk("bp_next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("bp_next_req_addr", 32'(imem_req_addr), 32'h11);

        // Wrap-around of the PC increment
        imem_req_ready = 1'b0;
        load_en        = 1'b1;
        load_addr      = 20'hFFFFF;
        tick();
        load_en = 1'b0;
        chk("wrap_req_addr_redir", 32'(imem_req_addr), 32'hFFFFF);
        chk("wrap_req_valid_redir", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        tick();
        tick();
        chk("wrap_ir_valid", 32'(ir_valid), 32'd1);
        chk("wrap_ir_data", 32'(ir_data), 32'h000FF);
        chk("wrap_ir_pc", 32'(ir_pc), 32'hFFFFF);
        tick();
        chk("wrap_next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("wrap_next_req_addr", 32'(imem_req_addr), 32'h00000);

        // Fresh start: three deliveries, one redirect-dropped, then reset mid-WAIT
        @(negedge clk);
        rst_n          = 1'b0;
        pend           = 1'b0;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) tick();
        chk("s_hold_ir_valid", 32'(ir_valid), 32'd1);
        chk("s_hold_ir_pc", 32'(ir_pc), 32'h3);
        load_en   = 1'b1;
        load_addr = 20'h00020;
        tick();
        load_en = 1'b0;
`ifdef FETCH_STATS_EN
        chk("s_fetch_count3", 32'(fetch_count), 32'd3);
`endif
        chk("s_redir_req_addr", 32'(imem_req_addr), 32'h20);
        lat = 3;
        tick();
        chk("s_wait_req_valid", 32'(imem_req_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("s_rst_req_addr", 32'(imem_req_addr), 32'd0);
        chk("s_rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("s_rst_ir_data", 32'(ir_data), 32'd0);
        chk("s_rst_ir_pc", 32'(ir_pc), 32'd0);
`ifdef FETCH_STATS_EN
        chk("s_rst_fetch_count", 32'(fetch_count), 32'd0);
`endif
        pend           = 1'b0;
        imem_rsp_valid = 1'b0;
        lat            = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("s_restart_req_valid", 32'(imem_req_valid), 32'd1);
        chk("s_restart_req_addr", 32'(imem_req_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
